// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_tx_sched_pkg;

   localparam int unsigned NUM_REQ       = 3;
   localparam logic [7:0]  MAX_LEN_DEF   = 8'd64;
   localparam logic [15:0] STALL_TMO_DEF = 16'd50000;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StSend = 2'd2
   } state_e;

   // Next requester index, wrapping 2 -> 0 (an out-of-range index also wraps to 0).
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin pick: search starts just after last_owner.
module rr_arb3
   import uart_tx_sched_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last_owner,
   output logic [2:0] gnt,
   output logic [1:0] gnt_idx
);

   logic [1:0] idx;
   logic       found;

   // Walk the three candidates in rotation order; first requester found wins.
   always_comb begin
      gnt     = 3'b000;
      gnt_idx = 2'd0;
      found   = 1'b0;
      idx     = last_owner;
      for (int k = 0; k < 3; k++) begin
         idx = next_idx(idx);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from three requesters onto one UART transmitter, one packet
// per grant, with length and stall limits that force a release.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int unsigned NREQ      = NUM_REQ,
   parameter logic [7:0]  MAX_LEN   = MAX_LEN_DEF,
   parameter logic [15:0] STALL_TMO = STALL_TMO_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ack,
   output logic              tx_ready,
   output logic [7:0]        tx_data,
   input  logic              tx_rd,
   output logic [NREQ-1:0]   grant,
   output logic              pkt_done,
   output logic              abort
);

   state_e          state_q, state_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      last_owner_q, last_owner_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [7:0]      byte_cnt_q, byte_cnt_d;
   logic [15:0]     stall_q, stall_d;
   logic            last_reg_q, last_reg_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_ready_q, tx_ready_d;
   logic [NREQ-1:0] req_ack_q, req_ack_d;
   logic            pkt_done_q, pkt_done_d;
   logic            abort_q, abort_d;

   logic [2:0]      arb_gnt;
   logic [1:0]      arb_idx;
   logic [7:0]      owner_byte;

   rr_arb3 u_arb (
      .req        (req_valid),
      .last_owner (last_owner_q),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx)
   );

   assign owner_byte = req_data[8*owner_q +: 8];

   // Next-state and registered-output logic for the scheduler FSM.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      grant_d      = grant_q;
      byte_cnt_d   = byte_cnt_q;
      stall_d      = stall_q;
      last_reg_d   = last_reg_q;
      tx_data_d    = tx_data_q;
      tx_ready_d   = tx_ready_q;
      req_ack_d    = '0;
      pkt_done_d   = 1'b0;
      abort_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               grant_d    = arb_gnt;
               owner_d    = arb_idx;
               byte_cnt_d = 8'd0;
               stall_d    = 16'd0;
               last_reg_d = 1'b0;
               state_d    = StLoad;
            end
         end

         StLoad: begin
            if (req_valid[owner_q]) begin
               tx_data_d          = owner_byte;
               last_reg_d         = req_last[owner_q];
               req_ack_d[owner_q] = 1'b1;
               tx_ready_d         = 1'b1;
               stall_d            = 16'd0;
               if (byte_cnt_q != 8'hFF) begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
               state_d = StSend;
            end else begin
               if (stall_q != 16'hFFFF) begin
                  stall_d = stall_q + 16'd1;
               end
               // A stall release always lands mid-packet, so it is always an abort.
               if (stall_d >= STALL_TMO) begin
                  last_owner_d = owner_q;
                  grant_d      = '0;
                  pkt_done_d   = 1'b1;
                  abort_d      = !last_reg_q;
                  state_d      = StIdle;
               end
            end
         end

         StSend: begin
            if (tx_rd) begin
               tx_ready_d = 1'b0;
               if (last_reg_q || (byte_cnt_q >= MAX_LEN)) begin
                  // A natural end wins over the length limit: abort only without last.
                  last_owner_d = owner_q;
                  grant_d      = '0;
                  pkt_done_d   = 1'b1;
                  abort_d      = !last_reg_q;
                  state_d      = StIdle;
               end else begin
                  state_d = StLoad;
               end
            end
         end

         default: begin
            state_d    = StIdle;
            grant_d    = '0;
            tx_ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= 2'd0;
         last_owner_q <= 2'd2;
         grant_q      <= '0;
         byte_cnt_q   <= 8'd0;
         stall_q      <= 16'd0;
         last_reg_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_ready_q   <= 1'b0;
         req_ack_q    <= '0;
         pkt_done_q   <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         grant_q      <= grant_d;
         byte_cnt_q   <= byte_cnt_d;
         stall_q      <= stall_d;
         last_reg_q   <= last_reg_d;
         tx_data_q    <= tx_data_d;
         tx_ready_q   <= tx_ready_d;
         req_ack_q    <= req_ack_d;
         pkt_done_q   <= pkt_done_d;
         abort_q      <= abort_d;
      end
   end

   assign req_ack  = req_ack_q;
   assign tx_ready = tx_ready_q;
   assign tx_data  = tx_data_q;
   assign grant    = grant_q;
   assign pkt_done = pkt_done_q;
   assign abort    = abort_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester and transmitter models, an event
// scoreboard checked every cycle, and directed scenarios with literal checks.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [23:0] req_data;
   logic [2:0]  req_last;
   logic [2:0]  req_ack;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_rd;
   logic [2:0]  grant;
   logic        pkt_done;
   logic        abort;

   int total = 0;
   int bad   = 0;
   int tx_hold = 1;
   logic mon_en = 1'b0;

   // Requester byte queues: {last, data}.
   logic [8:0] rq0[$];
   logic [8:0] rq1[$];
   logic [8:0] rq2[$];
   // Expected event streams, filled by the scenarios from the scheduling rules.
   logic [7:0] exp_bytes[$];
   logic [2:0] exp_grants[$];
   logic       exp_abort[$];

   uart_tx_sched #(
      .NREQ      (3),
      .MAX_LEN   (8'd4),
      .STALL_TMO (16'd10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ack   (req_ack),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_rd     (tx_rd),
      .grant     (grant),
      .pkt_done  (pkt_done),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got 0x%0h, want nothing", name, act);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int r, input logic last, input logic [7:0] b);
      case (r)
         0:       rq0.push_back({last, b});
         1:       rq1.push_back({last, b});
         default: rq2.push_back({last, b});
      endcase
   endtask

   task automatic wait_grant(output logic [2:0] g);
      int n = 0;
      while (grant == 3'b000 && n < 200) begin
         step();
         n++;
      end
      if (grant == 3'b000) miss("grant_timeout", n);
      g = grant;
   endtask

   task automatic wait_ready(input logic lvl);
      int n = 0;
      while (tx_ready !== lvl && n < 2000) begin
         step();
         n++;
      end
      if (tx_ready !== lvl) miss("tx_ready_timeout", n);
   endtask

   // Steps until pkt_done; reports the number of byte acks seen on the way.
   task automatic wait_done(output int acks);
      int n = 0;
      acks = 0;
      do begin
         step();
         n++;
         if (|req_ack) acks++;
      end while (!pkt_done && n < 3000);
      if (!pkt_done) miss("pkt_done_timeout", n);
   endtask

   // Requester model: present queue heads, pop on ack.
   initial begin : requesters
      req_valid = 3'b000;
      req_data  = 24'h0;
      req_last  = 3'b000;
      forever begin
         @(posedge clk);
         #1;
         if (req_ack[0] === 1'b1 && rq0.size() > 0) void'(rq0.pop_front());
         if (req_ack[1] === 1'b1 && rq1.size() > 0) void'(rq1.pop_front());
         if (req_ack[2] === 1'b1 && rq2.size() > 0) void'(rq2.pop_front());
         req_valid[0] = rq0.size() > 0;
         req_valid[1] = rq1.size() > 0;
         req_valid[2] = rq2.size() > 0;
         {req_last[0], req_data[7:0]}   = (rq0.size() > 0) ? rq0[0] : 9'h0;
         {req_last[1], req_data[15:8]}  = (rq1.size() > 0) ? rq1[0] : 9'h0;
         {req_last[2], req_data[23:16]} = (rq2.size() > 0) ? rq2[0] : 9'h0;
      end
   end

   // Transmitter model: tx_rd pulses after tx_ready has been seen tx_hold cycles.
   initial begin : transmitter
      int cnt;
      cnt   = 0;
      tx_rd = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tx_rd) begin
            tx_rd = 1'b0;
            cnt   = 0;
         end else if (rst_n === 1'b1 && tx_ready === 1'b1) begin
            cnt++;
            if (cnt >= tx_hold) tx_rd = 1'b1;
         end else begin
            cnt = 0;
         end
      end
   end

   // Scoreboard: every issued byte, new grant and release against expectations.
   initial begin : monitor
      logic       prev_ready;
      logic [7:0] prev_data;
      logic [2:0] prev_grant;
      prev_ready = 1'b0;
      prev_data  = 8'h00;
      prev_grant = 3'b000;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (grant != prev_grant) chk("grant_onehot0", 32'($countones(grant) <= 1), 1);
            if (prev_ready && tx_ready) chk("tx_data_stable", tx_data, prev_data);
            if (|req_ack) chk("ack_at_issue", {tx_ready & ~prev_ready, req_ack}, {1'b1, grant});
            if (tx_ready && !prev_ready) begin
               chk("ready_has_owner", 32'(grant != 3'b000), 1);
               if (exp_bytes.size() == 0) miss("tx_byte_unexpected", tx_data);
               else chk("tx_byte", tx_data, exp_bytes.pop_front());
            end
            if (grant != 3'b000 && prev_grant == 3'b000) begin
               if (exp_grants.size() == 0) miss("grant_unexpected", grant);
               else chk("grant_order", grant, exp_grants.pop_front());
            end
            if (pkt_done) begin
               if (exp_abort.size() == 0) miss("pkt_done_unexpected", abort);
               else chk("release_abort", abort, exp_abort.pop_front());
            end
            if (abort) chk("abort_with_done", pkt_done, 1);
         end
         prev_ready = tx_ready;
         prev_data  = tx_data;
         prev_grant = grant;
      end
   end

   initial begin : scenarios
      logic [2:0] g;
      logic [2:0] order[4];
      int         acks;
      int         n;
      int         high;

      // Reset state.
      rst_n = 1'b0;
      step();
      step();
      chk("rst_grant", grant, 3'b000);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_req_ack", req_ack, 3'b000);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_abort", abort, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step();

      // Requester 0: three bytes, last on 0x43.
      tx_hold = 1;
      exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h43);
      exp_grants.push_back(3'b001);
      exp_abort.push_back(1'b0);
      push(0, 1'b0, 8'h41); push(0, 1'b0, 8'h42); push(0, 1'b1, 8'h43);
      wait_done(acks);
      chk("t1_acks", acks, 3);
      chk("t1_abort", abort, 0);
      chk("t1_grant_released", grant, 3'b000);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (pkt_done) n++;
      end
      chk("t1_extra_done", n, 0);

      // Fresh reset, then all three requesters with 1-byte packets.
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'hB0);
      exp_bytes.push_back(8'hC0); exp_bytes.push_back(8'hA1);
      exp_grants.push_back(3'b001); exp_grants.push_back(3'b010);
      exp_grants.push_back(3'b100); exp_grants.push_back(3'b001);
      for (int i = 0; i < 4; i++) exp_abort.push_back(1'b0);
      push(0, 1'b1, 8'hA0); push(0, 1'b1, 8'hA1);
      push(1, 1'b1, 8'hB0);
      push(2, 1'b1, 8'hC0);
      for (int i = 0; i < 4; i++) begin
         wait_grant(g);
         order[i] = g;
         wait_done(acks);
      end
      chk("t2_grant0", order[0], 3'b001);
      chk("t2_grant1", order[1], 3'b010);
      chk("t2_grant2", order[2], 3'b100);
      chk("t2_grant3", order[3], 3'b001);

      // Requester 1 streams without last: cut at 4 bytes with abort.
      for (int i = 0; i < 5; i++) exp_bytes.push_back(8'(8'h10 + i));
      exp_grants.push_back(3'b010); exp_grants.push_back(3'b010);
      exp_abort.push_back(1'b1); exp_abort.push_back(1'b0);
      for (int i = 0; i < 4; i++) push(1, 1'b0, 8'(8'h10 + i));
      push(1, 1'b1, 8'h14);
      wait_done(acks);
      chk("t3_len_acks", acks, 4);
      chk("t3_len_abort", abort, 1);
      chk("t3_len_grant0", grant, 3'b000);
      wait_done(acks);
      chk("t3_tail_acks", acks, 1);
      chk("t3_tail_abort", abort, 0);

      // Requester 2: last lands exactly on the 4th byte -> normal release.
      for (int i = 0; i < 4; i++) exp_bytes.push_back(8'(8'h20 + i));
      exp_grants.push_back(3'b100);
      exp_abort.push_back(1'b0);
      for (int i = 0; i < 3; i++) push(2, 1'b0, 8'(8'h20 + i));
      push(2, 1'b1, 8'h23);
      wait_done(acks);
      chk("t4_acks", acks, 4);
      chk("t4_abort", abort, 0);

      // Requester 2 stalls after one byte; requester 0 waits.
      exp_bytes.push_back(8'h30); exp_bytes.push_back(8'h31);
      exp_grants.push_back(3'b100); exp_grants.push_back(3'b001);
      exp_abort.push_back(1'b1); exp_abort.push_back(1'b0);
      push(2, 1'b0, 8'h30);
      wait_grant(g);
      chk("t5_first_grant", g, 3'b100);
      push(0, 1'b1, 8'h31);
      wait_ready(1'b1);
      wait_ready(1'b0);
      n = 0;
      do begin
         step();
         n++;
      end while (!pkt_done && n < 50);
      chk("t5_stall_cycles", n, 10);
      chk("t5_stall_abort", abort, 1);
      wait_grant(g);
      chk("t5_next_grant", g, 3'b001);
      wait_done(acks);

      // Slow transmitter: 868 cycles of hold-off.
      tx_hold = 868;
      exp_bytes.push_back(8'h50);
      exp_grants.push_back(3'b001);
      exp_abort.push_back(1'b0);
      push(0, 1'b1, 8'h50);
      wait_ready(1'b1);
      high = 1;
      acks = 0;
      n    = 0;
      while (n < 2000) begin
         step();
         n++;
         if (!tx_ready) break;
         high++;
         if (|req_ack) acks++;
      end
      chk("t6_ready_cycles", high, 868);
      chk("t6_acks_in_wait", acks, 0);
      chk("t6_done_on_rd", pkt_done, 1);
      tx_hold = 1;
      step();

      // Reset while a byte is in flight.
      tx_hold = 20;
      exp_bytes.push_back(8'h60);
      exp_grants.push_back(3'b010);
      push(1, 1'b1, 8'h60);
      wait_ready(1'b1);
      step(); step(); step();
      rst_n = 1'b0;
      step();
      chk("t7_rst_ready", tx_ready, 0);
      chk("t7_rst_grant", grant, 3'b000);
      rst_n   = 1'b1;
      tx_hold = 1;
      exp_bytes.push_back(8'h61); exp_bytes.push_back(8'h62);
      exp_grants.push_back(3'b001); exp_grants.push_back(3'b010);
      exp_abort.push_back(1'b0); exp_abort.push_back(1'b0);
      push(0, 1'b1, 8'h61);
      push(1, 1'b1, 8'h62);
      wait_grant(g);
      chk("t7_first_grant", g, 3'b001);
      wait_done(acks);
      wait_done(acks);
      for (int i = 0; i < 4; i++) step();

      chk("left_bytes", exp_bytes.size(), 0);
      chk("left_grants", exp_grants.size(), 0);
      chk("left_releases", exp_abort.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
